// File: rtl/player_pkg.sv
// Shared pose encoding, screen constants and horizontal step helper for the player sprite.
// Latency: n/a (types/functions only). Backpressure: n/a.
package player_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_L = 2'd1,
    WALK_R = 2'd2,
    AIR    = 2'd3
  } player_state_t;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int ANIM_DIV = 8;

  // One frame of horizontal motion, clamped to [0, x_max]; go_left/go_right are exclusive.
  function automatic logic [11:0] step_x(
    input logic [11:0] x,
    input logic        go_left,
    input logic        go_right,
    input logic [11:0] step,
    input logic [11:0] x_max
  );
    logic [12:0] sum;
    sum    = {1'b0, x} + {1'b0, step};
    step_x = x;
    if (go_right) begin
      step_x = (sum > {1'b0, x_max}) ? x_max : sum[11:0];
    end else if (go_left) begin
      step_x = (x < step) ? 12'd0 : (x - step);
    end
  endfunction

endpackage

// File: rtl/player_jump_phys.sv
// Vertical integrator: jump launch, gravity, ground/ceiling clamp, updated once per frame strobe.
// Latency: ypos valid the cycle after the strobe edge; airborne_nxt is the combinational post-strobe view.
// Backpressure: none; frame is a single-cycle strobe and never stalls.
module player_jump_phys #(
  parameter int GROUND_Y = 500,
  parameter int JUMP_V   = 16,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        start_jump,
  output logic [11:0] ypos,
  output logic        airborne,
  output logic        airborne_nxt
);

  localparam logic [11:0]        GROUND   = 12'(GROUND_Y);
  localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);
  localparam logic signed [7:0]  JV       = 8'(JUMP_V);
  localparam logic signed [7:0]  GV       = 8'(GRAVITY);

  logic signed [7:0]  vy, vy_nxt;
  logic [11:0]        ypos_nxt;
  logic signed [12:0] ny;

  assign airborne     = (ypos != GROUND) || (vy != 8'sd0);
  assign airborne_nxt = (ypos_nxt != GROUND) || (vy_nxt != 8'sd0);

  always_comb begin
    ypos_nxt = ypos;
    vy_nxt   = vy;
    ny       = {1'b0, ypos} + {{5{vy[7]}}, vy};
    if (frame) begin
      if (start_jump) begin
        // Launch strobe already counts as the first airborne frame, so gravity applies now.
        ypos_nxt = GROUND - 12'(JUMP_V);
        vy_nxt   = GV - JV;
      end else if (airborne) begin
        if (ny >= GROUND_S) begin
          ypos_nxt = GROUND;
          vy_nxt   = 8'sd0;
        end else if (ny[12]) begin
          ypos_nxt = 12'd0;
          vy_nxt   = 8'sd0;
        end else begin
          ypos_nxt = ny[11:0];
          vy_nxt   = vy + GV;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ypos <= GROUND;
      vy   <= 8'sd0;
    end else begin
      ypos <= ypos_nxt;
      vy   <= vy_nxt;
    end
  end

endmodule

// File: rtl/player_move_ctl.sv
// Per-frame player motion: walk/clamp, jump via player_jump_phys, pose FSM; PLAYER_ANIM_EN adds walk animation.
// Latency: outputs update on the clk edge where vsync is first seen high, then hold until the next strobe.
// Backpressure: none; keyboard flags are sampled only on the frame strobe.
module player_move_ctl #(
  parameter int X_START  = 384,
  parameter int GROUND_Y = 500,
  parameter int PLAYER_W = 32,
  parameter int STEP     = 4,
  parameter int JUMP_V   = 16,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_tick,
  input  logic        a_pressed,
  input  logic        d_pressed,
  input  logic        w_pressed,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state,
  output logic [1:0]  anim_frame
);
  import player_pkg::*;

  localparam logic [11:0] X_MAX = 12'(SCREEN_W - PLAYER_W);

  logic          v_tick_q;
  logic          frame;
  logic          go_left, go_right;
  logic          airborne, airborne_nxt, start_jump;
  logic [11:0]   xpos_q, xpos_nxt;
  player_state_t state_q, state_nxt;

  assign frame      = v_tick & ~v_tick_q;
  assign go_left    = a_pressed & ~d_pressed;
  assign go_right   = d_pressed & ~a_pressed;
  assign start_jump = frame & w_pressed & ~airborne;

  player_jump_phys #(
    .GROUND_Y(GROUND_Y),
    .JUMP_V  (JUMP_V),
    .GRAVITY (GRAVITY)
  ) u_phys (
    .clk         (clk),
    .rst         (rst),
    .frame       (frame),
    .start_jump  (start_jump),
    .ypos        (ypos),
    .airborne    (airborne),
    .airborne_nxt(airborne_nxt)
  );

  always_comb begin
    xpos_nxt  = xpos_q;
    state_nxt = state_q;
    if (frame) begin
      xpos_nxt = step_x(xpos_q, go_left, go_right, 12'(STEP), X_MAX);
      // Pose follows the post-update position, so a landing strobe picks the walk pose directly.
      if (airborne_nxt)  state_nxt = AIR;
      else if (go_left)  state_nxt = WALK_L;
      else if (go_right) state_nxt = WALK_R;
      else               state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_tick_q <= 1'b0;
      xpos_q   <= 12'(X_START);
      state_q  <= IDLE;
    end else begin
      v_tick_q <= v_tick;
      xpos_q   <= xpos_nxt;
      state_q  <= state_nxt;
    end
  end

  assign xpos  = xpos_q;
  assign state = state_q;

`ifdef PLAYER_ANIM_EN
  localparam int DIV_W = $clog2(ANIM_DIV);

  logic [DIV_W-1:0] div_q;
  logic [1:0]       anim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      anim_q <= 2'd0;
    end else if (frame) begin
      case (state_nxt)
        IDLE: begin
          div_q  <= '0;
          anim_q <= 2'd0;
        end
        WALK_L, WALK_R: begin
          div_q <= div_q + 1'b1;
          if (div_q == DIV_W'(ANIM_DIV - 1)) anim_q <= anim_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign anim_frame = anim_q;
`else
  assign anim_frame = 2'd0;
`endif

endmodule
